// File: rtl/sram_capture_ctrl.sv
// Triggered, decimating 16-bit sample capture into a single-port SRAM, with
// 3-cycle random-access readback. Sole master of the SRAM port.
module sram_capture_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 65536,
    parameter int unsigned DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig,
    input  logic [DECIM_W-1:0] decim,
    input  logic               s_valid,
    input  logic [15:0]        s_data,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_ready,
    output logic               rd_valid,
    output logic [15:0]        rd_data,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    wr_count,
    output logic               ram_wen,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [15:0]        ram_wdata,
    input  logic [15:0]        ram_rdata
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;
    // RD_ADDR: address presented to SRAM; RD_LATCH: SRAM has latched it
    typedef enum logic [1:0] {RD_NONE, RD_ADDR, RD_LATCH} rd_stage_t;

    state_t               state_q, state_d;
    rd_stage_t            rd_stage_q, rd_stage_d;
    logic [DECIM_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0]     wr_count_d, wr_count_inc;
    logic                 ram_wen_d;
    logic [ADDR_W-1:0]    ram_addr_d;
    logic [15:0]          ram_wdata_d;
    logic [15:0]          rd_data_d;
    logic                 rd_valid_d, rd_ready_d, busy_d, done_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_stage_q <= RD_NONE;
            dec_cnt_q  <= '0;
            wr_count   <= '0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_stage_q <= rd_stage_d;
            dec_cnt_q  <= dec_cnt_d;
            wr_count   <= wr_count_d;
            ram_wen    <= ram_wen_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            rd_data    <= rd_data_d;
            rd_valid   <= rd_valid_d;
            rd_ready   <= rd_ready_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        rd_stage_d   = rd_stage_q;
        dec_cnt_d    = dec_cnt_q;
        wr_count_d   = wr_count;
        wr_count_inc = wr_count + CNT_W'(1);
        ram_wen_d    = 1'b0;
        ram_addr_d   = ram_addr;
        ram_wdata_d  = ram_wdata;
        rd_data_d    = rd_data;
        rd_valid_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d    = ST_ARMED;
                    wr_count_d = '0;
                    dec_cnt_d  = '0;
                end
            end
            ST_ARMED: begin
                // Trigger held off while a read owns ram_addr
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (trig && (rd_stage_q == RD_NONE)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    if (dec_cnt_q == '0) begin
                        ram_wen_d   = 1'b1;
                        ram_addr_d  = wr_count[ADDR_W-1:0];
                        ram_wdata_d = s_data;
                        wr_count_d  = wr_count_inc;
                        dec_cnt_d   = decim;
                        if (wr_count_inc == DEPTH_CNT) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q - DECIM_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read pipeline: ram_addr stays put until rd_data is taken, since the
        // SRAM decodes its output bank from the live address.
        case (rd_stage_q)
            RD_NONE: begin
                if (rd_req && rd_ready) begin
                    ram_addr_d = rd_addr;
                    ram_wen_d  = 1'b0;
                    rd_stage_d = RD_ADDR;
                end
            end
            RD_ADDR:  rd_stage_d = RD_LATCH;
            RD_LATCH: begin
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
                rd_stage_d = RD_NONE;
            end
            default: rd_stage_d = RD_NONE;
        endcase

        busy_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d     = (state_d == ST_DONE);
        rd_ready_d = ((state_d == ST_IDLE) || (state_d == ST_DONE)) && (rd_stage_d == RD_NONE);
    end

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Directed bench for sram_capture_ctrl: queue-based expectations for SRAM writes
// and read completions, checked every cycle, plus literal status checks.
module tb_sram_capture_ctrl;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DECIM_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                arm, abort, trig, s_valid, rd_req;
    logic [DECIM_W-1:0]  decim;
    logic [15:0]         s_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_ready, rd_valid, busy, done, ram_wen;
    logic [15:0]         rd_data, ram_wdata, ram_rdata;
    logic [ADDR_W:0]     wr_count;
    logic [ADDR_W-1:0]   ram_addr;

    sram_capture_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
        .decim(decim), .s_valid(s_valid), .s_data(s_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .busy(busy), .done(done), .wr_count(wr_count),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: unwritten words read back as their own address; address is
    // latched on the clock but the bank (top 2 bits) is decoded from the live address.
    logic [15:0]      wmem [DEPTH];
    logic [DEPTH-1:0] wvld;
    logic [15:0]      sram_aq;
    logic [15:0]      eff;
    logic             sram_clr;

    always @(posedge clk) begin
        if (sram_clr) begin
            wvld <= '0;
        end else if (ram_wen && (ram_addr < 16'(DEPTH))) begin
            wmem[ram_addr[2:0]] <= ram_wdata;
            wvld[ram_addr[2:0]] <= 1'b1;
        end
        sram_aq <= ram_addr;
    end

    assign eff       = {ram_addr[15:14], sram_aq[13:0]};
    assign ram_rdata = ((eff < 16'(DEPTH)) && wvld[eff[2:0]]) ? wmem[eff[2:0]] : eff;

    typedef struct { int due; logic [15:0] addr; logic [15:0] data; } rd_exp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_exp_t;
    rd_exp_t rq[$];
    wr_exp_t wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_rd(input int due, input logic [15:0] a, input logic [15:0] d);
        rd_exp_t e;
        e.due  = due;
        e.addr = a;
        e.data = d;
        rq.push_back(e);
    endtask

    // Per-cycle compare against the write/read expectation queues
    always @(negedge clk) begin
        if (ram_wen === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: ram_wen=1 addr=0x%0h data=0x%0h, required no write (cycle %0d)",
                         ram_addr, ram_wdata, cyc);
            end else begin
                chk("write_addr", 32'(ram_addr), 32'(wq[0].addr));
                chk("write_data", 32'(ram_wdata), 32'(wq[0].data));
                void'(wq.pop_front());
            end
        end
        if ((rq.size() != 0) && (rq[0].due == cyc)) begin
            chk("rd_valid_pulse", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(rq[0].data));
            chk("ram_addr_held_e3", 32'(ram_addr), 32'(rq[0].addr));
            void'(rq.pop_front());
        end else begin
            chk("rd_valid_quiet", 32'(rd_valid), 32'd0);
            if ((rq.size() != 0) && (cyc >= rq[0].due - 2))
                chk("ram_addr_held", 32'(ram_addr), 32'(rq[0].addr));
        end
    end

    // Issue one read at the current negedge; returns at the negedge of rd_valid
    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input bit poke, input bit ready_end);
        int due;
        due     = cyc + 3;
        rd_req  = 1'b1;
        rd_addr = a;
        push_rd(due, a, d);
        @(negedge clk);
        chk("rd_ready_inflight", 32'(rd_ready), 32'd0);
        if (poke) rd_addr = a ^ 16'h0003;
        else      rd_req  = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        for (int k = 0; k < 4 && cyc < due; k++) @(negedge clk);
        chk("rd_ready_end", 32'(rd_ready), 32'(ready_end));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    int sidx;

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; decim = '0;
        s_valid = 1'b0; s_data = '0; rd_req = 1'b0; rd_addr = '0; sram_clr = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_rd_ready", 32'(rd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        sram_clr = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Full capture, decim=0, trig-cycle sample not stored, 9th sample dropped
        decim = 8'd0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("armed_busy", 32'(busy), 32'd1);
        chk("armed_rd_ready", 32'(rd_ready), 32'd0);
        trig = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin
                chk("cap7_done", 32'(done), 32'd0);
                chk("cap7_wr_count", 32'(wr_count), 32'd7);
            end
            if (i == 8) begin
                chk("cap8_done", 32'(done), 32'd1);
                chk("cap8_wr_count", 32'(wr_count), 32'd8);
                chk("cap8_busy", 32'(busy), 32'd0);
            end
            s_valid = 1'b1;
            s_data  = 16'h1000 + 16'(i);
            if (i < 8) push_wr(16'(i), 16'h1000 + 16'(i));
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("done_wr_count", 32'(wr_count), 32'd8);
        chk("done_rd_ready", 32'(rd_ready), 32'd1);

        // Readback with a dropped request during the in-flight read
        do_read(16'd5, 16'h1005, 1'b1, 1'b1);
        // Bank-crossing reads, back to back from the rd_valid cycle
        do_read(16'h3FFF, 16'h3FFF, 1'b0, 1'b1);
        do_read(16'h4000, 16'h4000, 1'b0, 1'b1);
        do_read(16'hBFFF, 16'hBFFF, 1'b0, 1'b1);
        do_read(16'hC000, 16'hC000, 1'b0, 1'b1);

        // Decimation by 3: samples 1..9 keep 1,4,7
        decim = 8'd2;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("rearm_wr_count", 32'(wr_count), 32'd0);
        chk("rearm_done", 32'(done), 32'd0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        sidx = 0;
        for (int i = 1; i <= 9; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            if (i == 1 || i == 4 || i == 7) begin
                push_wr(16'(sidx), 16'(i));
                sidx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("decim_wr_count", 32'(wr_count), 32'd3);
        chk("decim_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("decim_abort_busy", 32'(busy), 32'd0);
        chk("decim_abort_wr_count", 32'(wr_count), 32'd3);
        do_read(16'd1, 16'h0004, 1'b0, 1'b1);
        do_read(16'd3, 16'h1003, 1'b0, 1'b1);

        // Abort after 3 stores; abort beats trig and a same-cycle store
        decim = 8'd0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h00A0 + 16'(i);
            push_wr(16'(i), 16'h00A0 + 16'(i));
            @(negedge clk);
        end
        abort = 1'b1; trig = 1'b1; s_data = 16'h00A3;
        @(negedge clk);
        abort = 1'b0; trig = 1'b0; s_valid = 1'b0;
        chk("abort_wr_count", 32'(wr_count), 32'd3);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_ready", 32'(rd_ready), 32'd1);

        // Arm during a read: read completes, trig ignored while it is in flight
        rd_req = 1'b1; rd_addr = 16'd2;
        push_rd(cyc + 3, 16'd2, 16'h00A2);
        @(negedge clk);
        rd_req = 1'b0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0; trig = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
        @(negedge clk);
        trig = 1'b0; s_valid = 1'b0;
        chk("armrd_busy", 32'(busy), 32'd1);
        chk("armrd_rd_ready", 32'(rd_ready), 32'd0);
        s_valid = 1'b1; s_data = 16'hBEE0;
        @(negedge clk);
        s_valid = 1'b0;
        chk("armrd_still_armed", 32'(busy), 32'd1);
        chk("armrd_wr_count", 32'(wr_count), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("armrd_abort_busy", 32'(busy), 32'd0);

        // Reset in the middle of a read: no rd_valid afterwards
        rd_req = 1'b1; rd_addr = 16'd5;
        @(negedge clk);
        rd_req = 1'b0;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_rd_ready", 32'(rd_ready), 32'd1);
        chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(16'd5, 16'h1005, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("reads_outstanding", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
